// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter for one external memory port; MEM_ARB_TIMEOUT_EN adds a BUSY watchdog
module mem_arbiter
`ifdef MEM_ARB_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT = 255)
`endif
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [15:0] i_if_addr,
  output logic        o_if_ready,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_read,
  input  logic        i_d_write,
  input  logic [15:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_ready,
  output logic [31:0] o_d_rdata,
  output logic [15:0] o_ext_mem_addr,
  output logic [31:0] o_ext_mem_wdata,
  output logic        o_ext_mem_read,
  output logic        o_ext_mem_write,
  input  logic [31:0] i_ext_mem_rdata,
  input  logic        i_ext_mem_ready,
  output logic        o_arb_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      r_state;
  logic        r_last_d;
  logic        r_sel_d;
  logic        w_dreq;
  logic        w_grant_d;
  logic        w_abort;
  logic        w_fin;
  logic [31:0] w_rdata;
  assign w_dreq    = i_d_read | i_d_write;
  assign w_grant_d = w_dreq & (~i_if_req | ~r_last_d);
`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  // Watchdog: cleared while idle, counts BUSY cycles that saw no acknowledge
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      r_cnt <= '0;
    else if (r_state == IDLE)
      r_cnt <= '0;
    else if (r_state == BUSY && !i_ext_mem_ready)
      r_cnt <= r_cnt + 16'd1;
  assign w_abort = (r_state == BUSY) & ~i_ext_mem_ready & (r_cnt == 16'(TIMEOUT - 1));
`else
  assign w_abort = 1'b0;
`endif
  assign w_fin   = i_ext_mem_ready | w_abort;
  assign w_rdata = (w_abort | o_ext_mem_write) ? '0 : i_ext_mem_rdata;
  // Grant, hold the command until acknowledged, then pulse ready for one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_last_d        <= 1'b0;
      r_sel_d         <= 1'b0;
      o_ext_mem_addr  <= '0;
      o_ext_mem_wdata <= '0;
      o_ext_mem_read  <= 1'b0;
      o_ext_mem_write <= 1'b0;
      o_if_ready      <= 1'b0;
      o_if_rdata      <= '0;
      o_d_ready       <= 1'b0;
      o_d_rdata       <= '0;
      o_arb_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_if_req | w_dreq) begin
          r_state         <= BUSY;
          r_sel_d         <= w_grant_d;
          r_last_d        <= w_grant_d;
          o_ext_mem_addr  <= w_grant_d ? i_d_addr : i_if_addr;
          o_ext_mem_wdata <= (w_grant_d & i_d_write) ? i_d_wdata : '0;
          o_ext_mem_write <= w_grant_d & i_d_write;
          o_ext_mem_read  <= ~(w_grant_d & i_d_write);
        end
        BUSY: if (w_fin) begin
          r_state         <= RESP;
          o_ext_mem_read  <= 1'b0;
          o_ext_mem_write <= 1'b0;
          o_if_ready      <= ~r_sel_d;
          o_d_ready       <= r_sel_d;
          o_if_rdata      <= r_sel_d ? '0 : w_rdata;
          o_d_rdata       <= r_sel_d ? w_rdata : '0;
          o_arb_err       <= w_abort;
        end
        default: begin
          r_state    <= IDLE;
          o_if_ready <= 1'b0;
          o_if_rdata <= '0;
          o_d_ready  <= 1'b0;
          o_d_rdata  <= '0;
          o_arb_err  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a round-robin and memory model
module tb_mem_arbiter;
  logic        i_clk;
  logic        i_rst_n;
  logic        i_if_req;
  logic [15:0] i_if_addr;
  logic        o_if_ready;
  logic [31:0] o_if_rdata;
  logic        i_d_read;
  logic        i_d_write;
  logic [15:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic        o_d_ready;
  logic [31:0] o_d_rdata;
  logic [15:0] o_ext_mem_addr;
  logic [31:0] o_ext_mem_wdata;
  logic        o_ext_mem_read;
  logic        o_ext_mem_write;
  logic [31:0] i_ext_mem_rdata;
  logic        i_ext_mem_ready;
  logic        o_arb_err;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        m_last_d;
  logic [31:0] mem [logic [15:0]];
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
  localparam int RMAX = 11;
  mem_arbiter #(.TIMEOUT(TO)) dut (
`else
  localparam int RMAX = 5;
  mem_arbiter dut (
`endif
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata),
    .i_d_read(i_d_read), .i_d_write(i_d_write), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_ready(o_d_ready), .o_d_rdata(o_d_rdata),
    .o_ext_mem_addr(o_ext_mem_addr), .o_ext_mem_wdata(o_ext_mem_wdata),
    .o_ext_mem_read(o_ext_mem_read), .o_ext_mem_write(o_ext_mem_write),
    .i_ext_mem_rdata(i_ext_mem_rdata), .i_ext_mem_ready(i_ext_mem_ready), .o_arb_err(o_arb_err)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] outs();
    return {o_ext_mem_addr, o_ext_mem_wdata, o_ext_mem_read, o_ext_mem_write,
            o_if_ready, o_d_ready, o_if_rdata, o_d_rdata, o_arb_err};
  endfunction
  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : {a, a ^ 16'hA5A5};
  endfunction
  task automatic rand_req(input logic free_if, input logic free_d);
    if (free_d) begin
      {i_d_read, i_d_write} = 2'($urandom);
      i_d_addr  = 16'($urandom_range(0, 15));
      i_d_wdata = $urandom;
    end
    if (free_if) begin
      i_if_req  = 1'($urandom);
      i_if_addr = 16'($urandom_range(0, 15));
    end
  endtask
  // one arbitration round from an IDLE-cycle negedge to the next; memory acks in BUSY cycle r
  // mode 0: served requester drops, 1: randomize free requesters, 2: keep requests
  task automatic round(input int r, input int mode, output logic sd);
    logic        req_d;
    logic        exp_wr;
    logic        err;
    logic [15:0] ea;
    logic [31:0] ew;
    logic [31:0] mv;
    logic [31:0] er;
    int          len;
    req_d = i_d_read | i_d_write;
    sd = 1'b0;
    if (!i_if_req && !req_d) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("idle_nocmd", {o_ext_mem_read, o_ext_mem_write, o_if_ready, o_d_ready}, 0);
      if (mode == 1) rand_req(1'b1, 1'b1);
      return;
    end
    sd = req_d && (!i_if_req || !m_last_d);
    m_last_d = sd;
    exp_wr = sd && i_d_write;
    ea = sd ? i_d_addr : i_if_addr;
    ew = exp_wr ? i_d_wdata : 32'h0;
    len = r;
    err = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    if (r > TO) begin
      len = TO;
      err = 1'b1;
    end
`endif
    mv = mem_rd(ea);
    for (int c = 1; c <= len; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("cmd_rd", o_ext_mem_read, !exp_wr);
      chk("cmd_wr", o_ext_mem_write, exp_wr);
      chk("cmd_addr", o_ext_mem_addr, ea);
      chk("cmd_wdata", o_ext_mem_wdata, ew);
      chk("busy_quiet", {o_if_ready, o_d_ready, o_arb_err, o_if_rdata, o_d_rdata}, 0);
      i_ext_mem_ready = (c == len) && !err;
      i_ext_mem_rdata = ((c == len) && !err) ? mv : $urandom;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    er = (err || exp_wr) ? 32'h0 : mv;
    chk("rdy_if", o_if_ready, !sd);
    chk("rdy_d", o_d_ready, sd);
    chk("rdata_if", o_if_rdata, sd ? 32'h0 : er);
    chk("rdata_d", o_d_rdata, sd ? er : 32'h0);
    chk("arb_err", o_arb_err, err);
    chk("resp_nocmd", {o_ext_mem_read, o_ext_mem_write}, 0);
    if (exp_wr && !err) mem[ea] = ew;
    i_ext_mem_ready = 1'($urandom);
    i_ext_mem_rdata = $urandom;
    if (mode == 0) begin
      if (sd) {i_d_read, i_d_write} = 2'b00;
      else i_if_req = 1'b0;
    end else if (mode == 1) begin
      rand_req(!sd || !i_if_req, sd || !req_d);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    chk("idle_after", {o_ext_mem_read, o_ext_mem_write, o_if_ready, o_d_ready, o_arb_err}, 0);
  endtask
  initial begin
    logic sd;
    i_rst_n = 1'b0;
    i_if_req = 1'b0;
    i_if_addr = '0;
    i_d_read = 1'b0;
    i_d_write = 1'b0;
    i_d_addr = '0;
    i_d_wdata = '0;
    i_ext_mem_rdata = '0;
    i_ext_mem_ready = 1'b0;
    m_last_d = 1'b0;
    #1;
    chk("reset_outs", outs(), 0);
    repeat (2) @(negedge i_clk);
    chk("reset_hold", outs(), 0);
    i_rst_n = 1'b1;
    i_if_req = 1'b1;
    i_if_addr = 16'h0003;
    i_d_read = 1'b1;
    i_d_addr = 16'h0007;
    for (int i = 0; i < 4; i++) begin
      round(1 + i, 2, sd);
      chk("tie_order", sd, (i % 2) == 0);
    end
    {i_d_read, i_d_write} = 2'b00;
    i_if_addr = 16'h0010;
    mem[16'h0010] = 32'h1234_5678;
    round(1, 0, sd);
    i_d_write = 1'b1;
    i_d_addr = 16'h0004;
    i_d_wdata = 32'hCAFE_0001;
    round(4, 0, sd);
    i_d_read = 1'b1;
    round(2, 0, sd);
    for (int i = 0; i < 300; i++) round($urandom_range(1, RMAX), 1, sd);
    i_if_req = 1'b1;
    i_if_addr = 16'h0005;
    {i_d_read, i_d_write} = 2'b00;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ext_mem_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("pre_rst_busy", o_ext_mem_read, 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", outs(), 0);
    i_if_req = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_mid_hold", outs(), 0);
    m_last_d = 1'b0;
    i_rst_n = 1'b1;
    i_if_req = 1'b1;
    i_if_addr = 16'h0009;
    i_d_read = 1'b1;
    i_d_addr = 16'h0002;
    round(1, 0, sd);
    chk("rst_ptr_d", sd, 1);
    round(1, 0, sd);
    chk("rst_ptr_i", sd, 0);
    i_if_addr = 16'h000B;
`ifdef MEM_ARB_TIMEOUT_EN
    i_if_req = 1'b1;
    round(TO, 0, sd);
    i_if_req = 1'b1;
    round(TO + 1, 0, sd);
`endif
    i_if_req = 1'b1;
    round(1001, 0, sd);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single external memory interface between the instruction-fetch path and the data-memory (MEM-stage) path of the soc. It sits between those two requesters and the external memory pins (16-bit word address, 32-bit data). It runs one transaction at a time, holds the command stable until the memory acknowledges, and returns a one-cycle ready pulse with registered read data to the granted requester. Simultaneous requests are resolved round-robin.

## Interface
- TIMEOUT, 255: cycles in BUSY before a stuck transaction is aborted (used only with MEM_ARB_TIMEOUT_EN); range 1..65535.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  instruction fetch read request.
- if_addr  in  16  fetch word address.
- if_ready  out  1  one-cycle fetch completion pulse.
- if_rdata  out  32  fetch read data, valid while if_ready=1.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_addr  in  16  data address.
- d_wdata  in  32  data write value.
- d_ready  out  1  one-cycle data completion pulse.
- d_rdata  out  32  data read data, valid while d_ready=1 for reads.
- ext_mem_addr  out  16  external memory address.
- ext_mem_wdata  out  32  external write data.
- ext_mem_read  out  1  external read enable.
- ext_mem_write  out  1  external write enable.
- ext_mem_rdata  in  32  external read data.
- ext_mem_ready  in  1  external operation complete.
- arb_err  out  1  one-cycle pulse, coincident with ready, when a transaction was aborted by timeout.

## Operation
- States: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE: if any request pending, grant, latch addr/wdata/op into registers, go BUSY. No request: stay.
- Data request = d_read | d_write; d_read and d_write both high -> write (d_read ignored).
- Arbitration: 1-bit last-grant pointer. Only one requester -> it wins. Both -> the one not served last. Reset pointer = fetch, so data wins the first tie. Pointer updates on each grant.
- BUSY: ext_mem_addr/wdata/read/write driven from latched registers, held constant. On ext_mem_ready=1 sampled: capture ext_mem_rdata into response register, go RESP.
- RESP: assert granted requester's ready for exactly one cycle with its rdata; ext_mem_read/write=0; go IDLE. Writes return rdata=0.
- Requesters hold request and operands stable until their ready pulse and must drop or change the request in the cycle following it; a request still high in IDLE after RESP is treated as new.
- ext_mem_ready outside BUSY ignored.
- if_rdata/d_rdata: 0 except during own ready pulse.

## Timing
- Reset (rst=0, any time, including mid-BUSY): immediately all outputs 0 (ext_mem_addr=0, ext_mem_wdata=0, ext_mem_read=0, ext_mem_write=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, arb_err=0), state IDLE, pointer=fetch, timeout counter 0. In-flight transaction dropped, no ready pulse.
- Request sampled at edge 0 -> ext command high from cycle 1.
- ext_mem_ready high in cycle k (k>=1) -> ready pulse in cycle k+1 -> IDLE in cycle k+2; next grant's command earliest cycle k+3.
- Minimum transaction: 3 cycles request-to-IDLE; back-to-back throughput one transaction per 3 cycles with zero-wait memory.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: 16-bit counter cleared on BUSY entry, increments each BUSY cycle without ext_mem_ready; on reaching TIMEOUT go RESP with rdata=0 and arb_err=1 alongside the ready pulse. ext_mem_ready in the same cycle as expiry wins (normal completion, arb_err=0).
- Not defined: no counter; BUSY waits indefinitely; arb_err tied 0.

## Test plan
- Single fetch: if_req=1, if_addr=16'h0010, memory returns 32'h1234_5678 with ready in cycle 1 -> ext_mem_read=1, ext_mem_addr=16'h0010 cycle 1; if_ready=1, if_rdata=32'h1234_5678 cycle 2; IDLE cycle 3.
- Data write with wait states: d_write=1, d_addr=16'h0004, d_wdata=32'hCAFE_0001, ext_mem_ready after 4 cycles -> ext_mem_write/addr/wdata stable all 4 cycles, one d_ready pulse, d_rdata=0.
- Tie after reset: if_req and d_read both high -> data served first, then fetch; alternates on continued ties (D,I,D,I).
- Reset mid-BUSY: rst low in 2nd wait cycle -> all outputs 0 same cycle, no ready pulse; after release fresh request completes normally.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=8): ext_mem_ready never asserted -> after 8 BUSY cycles ready pulse with rdata=0 and arb_err=1; without macro, remains BUSY for 1000 cycles with arb_err=0.
